time_entry: RTL and testbench

- Operator-side front end for the microwave countdown timer.
- Conditions raw push-buttons and lets the user set minutes and seconds.
- Drives the timer's min/sec value bus and its start/stop/pause command inputs.
- Tracks the timer's run state through the timer's done output: issues commands, then observes the timer's response.

---
 rtl/time_entry_pkg.sv | 46 ++++
 rtl/time_entry_btn_conditioner.sv | 105 ++++++++++
 rtl/time_entry.sv | 171 +++++++++++++++++
 tb/tb_time_entry.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_entry_pkg.sv
// rtl/time_entry_pkg.sv - shared constants and action arbitration for the timer front end
package time_entry_pkg;

  // Operator state encoding
  localparam logic [1:0] SET    = 2'd0;
  localparam logic [1:0] ARM    = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;
  localparam logic [1:0] PAUSED = 2'd3;

  localparam logic [6:0] MAX_MIN = 7'd99;
  localparam logic [6:0] MAX_SEC = 7'd59;

  // Bit positions of each button in the press vector
  localparam int BTN_SEC_UP = 0;
  localparam int BTN_SEC_DN = 1;
  localparam int BTN_MIN_UP = 2;
  localparam int BTN_MIN_DN = 3;
  localparam int BTN_START  = 4;
  localparam int BTN_STOP   = 5;
  localparam int BTN_PAUSE  = 6;
  localparam int NUM_BTN    = 7;

  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_STOP,
    ACT_START,
    ACT_PAUSE,
    ACT_MIN_UP,
    ACT_MIN_DN,
    ACT_SEC_UP,
    ACT_SEC_DN
  } action_t;

  // Highest-priority press wins; everything else in that cycle is dropped
  function automatic action_t pick_action(input logic [NUM_BTN-1:0] p);
    if (p[BTN_STOP])   return ACT_STOP;
    if (p[BTN_START])  return ACT_START;
    if (p[BTN_PAUSE])  return ACT_PAUSE;
    if (p[BTN_MIN_UP]) return ACT_MIN_UP;
    if (p[BTN_MIN_DN]) return ACT_MIN_DN;
    if (p[BTN_SEC_UP]) return ACT_SEC_UP;
    if (p[BTN_SEC_DN]) return ACT_SEC_DN;
    return ACT_NONE;
  endfunction

endpackage

// File: rtl/time_entry_btn_conditioner.sv
// rtl/time_entry_btn_conditioner.sv - synchronise, debounce and edge-detect one button, optional auto-repeat
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter bit REPEAT_EN       = 1'b0,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_RATE     = 5_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic            sync_a;
  logic            sync_b;
  logic            level;
  logic            level_d;
  logic [DB_W-1:0] db_cnt;
  logic            rise;
  logic            repeat_fire;

  // Two-flop synchroniser; resets to "held" so a button down at reset is not seen as a press
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_a <= 1'b1;
      sync_b <= 1'b1;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
    end
  end

  // Accept a new level only after it has held for DEBOUNCE_CYCLES consecutive cycles
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      db_cnt <= '0;
      level  <= 1'b1;
    end else if (sync_b == level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt <= '0;
      level  <= sync_b;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  assign rise = level & ~level_d;

  // Register the debounced edge (or a repeat step) into a one-cycle press
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level_d <= 1'b1;
      press   <= 1'b0;
    end else begin
      level_d <= level;
      press   <= rise | repeat_fire;
    end
  end

  generate
    if (REPEAT_EN) begin : g_rep
      localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
      localparam int RP_W   = $clog2(RP_MAX + 1);

      logic            rp_active;
      logic            rp_fast;
      logic [RP_W-1:0] rp_cnt;
      logic            rp_hit;

      assign rp_hit      = rp_fast ? (rp_cnt == RP_W'(REPEAT_RATE - 1))
                                   : (rp_cnt == RP_W'(REPEAT_DELAY - 1));
      assign repeat_fire = rp_active & level & rp_hit;

      // Long initial delay after the press, then a fixed step rate while held
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          rp_active <= 1'b0;
          rp_fast   <= 1'b0;
          rp_cnt    <= '0;
        end else if (!level) begin
          rp_active <= 1'b0;
          rp_fast   <= 1'b0;
          rp_cnt    <= '0;
        end else if (rise) begin
          rp_active <= 1'b1;
          rp_fast   <= 1'b0;
          rp_cnt    <= '0;
        end else if (rp_active) begin
          if (rp_hit) begin
            rp_fast <= 1'b1;
            rp_cnt  <= '0;
          end else begin
            rp_cnt <= rp_cnt + 1'b1;
          end
        end
      end
    end else begin : g_norep
      assign repeat_fire = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/time_entry.sv
// rtl/time_entry.sv - operator front end: button handling, min/sec entry and timer command FSM
module time_entry
  import time_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_RATE     = 5_000_000,
  parameter int QUICK_SEC       = 30,
  parameter int ARM_TIMEOUT     = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_sec_up,
  input  logic       btn_sec_dn,
  input  logic       btn_min_up,
  input  logic       btn_min_dn,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_pause,
  input  logic       done,
  output logic [6:0] min,
  output logic [6:0] sec,
  output logic       start,
  output logic       stop,
  output logic       pause,
  output logic       editing
);

  localparam int ARM_W = $clog2(ARM_TIMEOUT + 1);

  logic [NUM_BTN-1:0] raw_btn;
  logic [NUM_BTN-1:0] press;
  action_t            act;

  logic [1:0]       state, state_nxt;
  logic [6:0]       min_nxt, sec_nxt;
  logic             start_nxt, stop_nxt, pause_nxt;
  logic [ARM_W-1:0] arm_cnt, arm_nxt;

  assign raw_btn = {btn_pause, btn_stop, btn_start, btn_min_dn, btn_min_up, btn_sec_dn, btn_sec_up};

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      btn_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .REPEAT_EN      (gi <= BTN_MIN_DN),
        .REPEAT_DELAY   (REPEAT_DELAY),
        .REPEAT_RATE    (REPEAT_RATE)
      ) u_cond (
        .clock(clock),
        .reset(reset),
        .btn  (raw_btn[gi]),
        .press(press[gi])
      );
    end
  endgenerate

  // Next state, entry value and command pulses from the winning action and the timer's done flag
  always_comb begin
    act       = pick_action(press);
    state_nxt = state;
    min_nxt   = min;
    sec_nxt   = sec;
    start_nxt = 1'b0;
    stop_nxt  = 1'b0;
    pause_nxt = 1'b0;
    arm_nxt   = arm_cnt;
    case (state)
      SET: begin
        case (act)
          ACT_STOP: begin
            min_nxt = 7'd0;
            sec_nxt = 7'd0;
          end
          ACT_START: begin
            if (min == 7'd0 && sec == 7'd0) sec_nxt = 7'(QUICK_SEC);
            start_nxt = 1'b1;
            state_nxt = ARM;
            arm_nxt   = '0;
          end
          ACT_MIN_UP: if (min < MAX_MIN) min_nxt = min + 7'd1;
          ACT_MIN_DN: if (min != 7'd0) min_nxt = min - 7'd1;
          ACT_SEC_UP: begin
            if (sec < MAX_SEC) begin
              sec_nxt = sec + 7'd1;
            end else if (min < MAX_MIN) begin
              sec_nxt = 7'd0;
              min_nxt = min + 7'd1;
            end
          end
          ACT_SEC_DN: begin
            if (sec != 7'd0) begin
              sec_nxt = sec - 7'd1;
            end else if (min != 7'd0) begin
              sec_nxt = MAX_SEC;
              min_nxt = min - 7'd1;
            end
          end
          default: ;
        endcase
      end
      ARM: begin
        if (act == ACT_STOP) begin
          stop_nxt  = 1'b1;
          state_nxt = SET;
        end else if (!done) begin
          state_nxt = RUN;
        end else if (arm_cnt == ARM_W'(ARM_TIMEOUT - 1)) begin
          state_nxt = SET;
        end else begin
          arm_nxt = arm_cnt + 1'b1;
        end
      end
      RUN: begin
        if (act == ACT_STOP) begin
          stop_nxt  = 1'b1;
          state_nxt = SET;
          min_nxt   = 7'd0;
          sec_nxt   = 7'd0;
        end else if (done) begin
          state_nxt = SET;
          min_nxt   = 7'd0;
          sec_nxt   = 7'd0;
        end else if (act == ACT_PAUSE) begin
          pause_nxt = 1'b1;
          state_nxt = PAUSED;
        end
      end
      default: begin
        if (act == ACT_STOP) begin
          stop_nxt  = 1'b1;
          state_nxt = SET;
          min_nxt   = 7'd0;
          sec_nxt   = 7'd0;
        end else if (done) begin
          state_nxt = SET;
          min_nxt   = 7'd0;
          sec_nxt   = 7'd0;
        end else if (act == ACT_START || act == ACT_PAUSE) begin
          start_nxt = 1'b1;
          state_nxt = RUN;
        end
      end
    endcase
  end

  // Register state, value, pulses and the editing flag together
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= SET;
      min     <= 7'd0;
      sec     <= 7'd0;
      start   <= 1'b0;
      stop    <= 1'b0;
      pause   <= 1'b0;
      arm_cnt <= '0;
      editing <= 1'b1;
    end else begin
      state   <= state_nxt;
      min     <= min_nxt;
      sec     <= sec_nxt;
      start   <= start_nxt;
      stop    <= stop_nxt;
      pause   <= pause_nxt;
      arm_cnt <= arm_nxt;
      editing <= (state_nxt == SET);
    end
  end

endmodule

// File: tb/tb_time_entry.sv
// tb/tb_time_entry.sv - directed self-checking bench for time_entry
module tb_time_entry;
  import time_entry_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [6:0] raw;
  logic       done;
  logic [6:0] min, sec;
  logic       start, stop, pause, editing;

  int total = 0;
  int bad   = 0;

  int n_start = 0, n_stop = 0, n_pause = 0, n_overlap = 0, n_wide = 0;
  logic start_q = 1'b0, stop_q = 1'b0, pause_q = 1'b0;

  time_entry #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_RATE    (5),
    .QUICK_SEC      (30),
    .ARM_TIMEOUT    (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .btn_sec_up(raw[BTN_SEC_UP]),
    .btn_sec_dn(raw[BTN_SEC_DN]),
    .btn_min_up(raw[BTN_MIN_UP]),
    .btn_min_dn(raw[BTN_MIN_DN]),
    .btn_start (raw[BTN_START]),
    .btn_stop  (raw[BTN_STOP]),
    .btn_pause (raw[BTN_PAUSE]),
    .done      (done),
    .min       (min),
    .sec       (sec),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .editing   (editing)
  );

  always #5 clock = ~clock;

  // Tally command pulses, overlapping pulses and pulses wider than one cycle
  always @(negedge clock) begin
    if (start) n_start <= n_start + 1;
    if (stop)  n_stop  <= n_stop + 1;
    if (pause) n_pause <= n_pause + 1;
    if (int'(start) + int'(stop) + int'(pause) > 1) n_overlap <= n_overlap + 1;
    if ((start && start_q) || (stop && stop_q) || (pause && pause_q)) n_wide <= n_wide + 1;
    start_q <= start;
    stop_q  <= stop;
    pause_q <= pause;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic tap(input int idx);
    raw[idx] = 1'b1;
    cyc(8);
    raw[idx] = 1'b0;
    cyc(12);
  endtask

  task automatic wait_sig(input int which, input int budget, output bit seen);
    int n;
    seen = 1'b0;
    n = 0;
    while (!seen && n < budget) begin
      cyc(1);
      n++;
      case (which)
        0:       seen = start;
        1:       seen = stop;
        default: seen = pause;
      endcase
    end
  endtask

  initial begin
    bit seen;
    int s0, s1;

    reset = 1'b1;
    raw   = '0;
    done  = 1'b1;
    cyc(2);
    check("rst_min", min, 0);
    check("rst_sec", sec, 0);
    check("rst_pulses", {start, stop, pause}, 0);
    check("rst_editing", editing, 1);
    reset = 1'b0;
    cyc(10);

    // bounce then a clean hold: exactly one increment
    for (int i = 0; i < 3; i++) begin
      raw[BTN_SEC_UP] = 1'b1; cyc(1);
      raw[BTN_SEC_UP] = 1'b0; cyc(1);
    end
    check("bounce_none", sec, 0);
    tap(BTN_SEC_UP);
    check("bounce_sec", sec, 1);
    check("bounce_min", min, 0);

    // build 00:58 and exercise wrap/borrow
    tap(BTN_SEC_DN);
    tap(BTN_MIN_UP);
    check("min_up_1", min, 1);
    tap(BTN_SEC_DN);
    check("borrow", {min, sec}, {7'd0, 7'd59});
    tap(BTN_SEC_DN);
    check("at_58", sec, 58);

    // auto-repeat: press at edge 7, repeats at 27,32,37,42
    raw[BTN_SEC_UP] = 1'b1;
    cyc(8);
    check("rep_press", {min, sec}, {7'd0, 7'd59});
    cyc(20);
    check("rep_wrap", {min, sec}, {7'd1, 7'd0});
    cyc(12);
    raw[BTN_SEC_UP] = 1'b0;
    cyc(12);
    check("rep_final", {min, sec}, {7'd1, 7'd3});

    // min saturates at 99 under a long hold
    raw[BTN_MIN_UP] = 1'b1;
    cyc(600);
    raw[BTN_MIN_UP] = 1'b0;
    cyc(12);
    check("min_sat", {min, sec}, {7'd99, 7'd3});

    // stop in SET clears without a stop pulse
    s0 = n_stop;
    tap(BTN_STOP);
    check("set_stop_clear", {min, sec}, 0);
    check("set_stop_nopulse", n_stop - s0, 0);
    tap(BTN_SEC_DN);
    check("sec_dn_hold", {min, sec}, 0);

    // quick start from 00:00
    raw[BTN_START] = 1'b1;
    wait_sig(0, 30, seen);
    check("qs_pulse", seen, 1);
    check("qs_sec", {min, sec}, {7'd0, 7'd30});
    check("qs_arm", dut.state, ARM);
    cyc(1);
    check("qs_width", start, 0);
    cyc(2);
    done = 1'b0;
    cyc(1);
    check("qs_run", dut.state, RUN);
    check("qs_editing", editing, 0);
    raw[BTN_START] = 1'b0;
    cyc(10);
    done = 1'b1;
    cyc(1);
    check("expire_state", dut.state, SET);
    check("expire_clear", {min, sec}, 0);
    check("expire_editing", editing, 1);

    // 02:15 through pause / resume / stop
    tap(BTN_MIN_UP);
    tap(BTN_MIN_UP);
    for (int i = 0; i < 15; i++) tap(BTN_SEC_UP);
    check("v_0215", {min, sec}, {7'd2, 7'd15});
    raw[BTN_START] = 1'b1;
    wait_sig(0, 30, seen);
    check("p_start", seen, 1);
    cyc(1);
    done = 1'b0;
    cyc(1);
    raw[BTN_START] = 1'b0;
    cyc(10);
    check("p_run_value", {min, sec}, {7'd2, 7'd15});
    raw[BTN_PAUSE] = 1'b1;
    wait_sig(2, 30, seen);
    check("p_pause", seen, 1);
    check("p_paused", dut.state, PAUSED);
    raw[BTN_PAUSE] = 1'b0;
    cyc(12);
    raw[BTN_START] = 1'b1;
    wait_sig(0, 30, seen);
    check("p_resume", seen, 1);
    check("p_resume_run", dut.state, RUN);
    raw[BTN_START] = 1'b0;
    cyc(12);
    raw[BTN_STOP] = 1'b1;
    wait_sig(1, 30, seen);
    check("p_stop", seen, 1);
    check("p_stop_set", dut.state, SET);
    check("p_stop_clear", {min, sec}, 0);
    raw[BTN_STOP] = 1'b0;
    cyc(12);

    // start and stop together in RUN: stop wins
    done = 1'b1;
    raw[BTN_START] = 1'b1;
    wait_sig(0, 30, seen);
    cyc(1);
    done = 1'b0;
    cyc(1);
    raw[BTN_START] = 1'b0;
    cyc(12);
    check("ss_run", dut.state, RUN);
    s0 = n_start;
    s1 = n_stop;
    raw[BTN_START] = 1'b1;
    raw[BTN_STOP]  = 1'b1;
    wait_sig(1, 30, seen);
    cyc(3);
    check("ss_stop_cnt", n_stop - s1, 1);
    check("ss_start_cnt", n_start - s0, 0);
    check("ss_set", {dut.state, min, sec}, {SET, 7'd0, 7'd0});
    raw[BTN_START] = 1'b0;
    raw[BTN_STOP]  = 1'b0;
    cyc(12);

    // arm timeout with done stuck high
    tap(BTN_SEC_UP);
    done = 1'b1;
    raw[BTN_START] = 1'b1;
    wait_sig(0, 30, seen);
    check("to_start", seen, 1);
    cyc(7);
    check("to_still_arm", dut.state, ARM);
    cyc(1);
    check("to_set", dut.state, SET);
    check("to_kept", {min, sec}, {7'd0, 7'd1});
    raw[BTN_START] = 1'b0;
    cyc(12);

    // asynchronous reset mid-RUN with a button held through it
    raw[BTN_START] = 1'b1;
    wait_sig(0, 30, seen);
    cyc(1);
    done = 1'b0;
    cyc(1);
    raw[BTN_START] = 1'b0;
    cyc(12);
    check("r_run", dut.state, RUN);
    raw[BTN_SEC_UP] = 1'b1;
    reset = 1'b1;
    #1;
    check("r_async_val", {min, sec}, 0);
    check("r_async_cmd", {start, stop, pause}, 0);
    check("r_async_edit", editing, 1);
    cyc(2);
    reset = 1'b0;
    done  = 1'b1;
    cyc(30);
    check("r_held_ignored", sec, 0);
    raw[BTN_SEC_UP] = 1'b0;
    cyc(12);
    tap(BTN_SEC_UP);
    check("r_repress", sec, 1);

    cyc(2);
    check("no_overlap", n_overlap, 0);
    check("no_wide", n_wide, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
